// File: rtl/keypad_bcd_encoder.sv
// Keypad (10 key lines) to BCD encoder: sync, debounce, multi-key reject, valid/ready output.
// Optional auto-repeat of a held single key is built when KEY_REPEAT_EN is defined.
module keypad_bcd_encoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] key_in,
    output logic [3:0] bcd,
    output logic       bcd_valid,
    input  logic       bcd_ready,
    output logic       multi_err,
    output logic       overrun,
    input  logic       clr_overrun,
    output logic       busy
);

`ifdef KEY_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_LIM = (RPT_MAX > DEBOUNCE_CYCLES) ? RPT_MAX : DEBOUNCE_CYCLES;
`else
    // Repeat parameters never influence sizing when auto-repeat is not built.
    localparam int CNT_LIM = DEBOUNCE_CYCLES + 0 * (REPEAT_DELAY + REPEAT_PERIOD);
`endif
    localparam int CNT_W = $clog2(CNT_LIM + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT, HOLD} state_t;

    function automatic logic [3:0] key_code(input logic [9:0] k);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) c = 4'(i);
        end
        return c;
    endfunction

    function automatic logic is_multi(input logic [9:0] k);
        return (k & (k - 10'd1)) != 10'd0;
    endfunction

    logic [9:0]       sync1_q, sync1_d;
    logic [9:0]       key_s_q, key_s_d;
    state_t           state_q, state_d;
    logic [9:0]       sample_q, sample_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bcd_q, bcd_d;
    logic             bcd_valid_q, bcd_valid_d;
    logic             multi_err_q, multi_err_d;
    logic             overrun_q, overrun_d;
    logic             emit;
    logic             out_free;

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_arm_q, rpt_arm_d;
    logic             rpt_first_q, rpt_first_d;
`endif

    always_comb begin
        sync1_d     = key_in;
        key_s_d     = sync1_q;
        state_d     = state_q;
        sample_d    = sample_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        bcd_valid_d = bcd_valid_q;
        multi_err_d = 1'b0;
        overrun_d   = overrun_q;
        emit        = 1'b0;
        out_free    = !bcd_valid_q || bcd_ready;
`ifdef KEY_REPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;
        rpt_arm_d   = rpt_arm_q;
        rpt_first_d = rpt_first_q;
`endif

        case (state_q)
            IDLE: begin
                if (key_s_q != 10'd0) begin
                    state_d  = DEBOUNCE;
                    sample_d = key_s_q;
                    cnt_d    = '0;
                end
            end
            DEBOUNCE: begin
                if (key_s_q == sample_q) begin
                    if (cnt_q == DEB_LAST) begin
                        cnt_d = '0;
                        if (is_multi(sample_q)) begin
                            multi_err_d = 1'b1;
                            state_d     = HOLD;
`ifdef KEY_REPEAT_EN
                            rpt_arm_d   = 1'b0;
`endif
                        end else begin
                            state_d = EMIT;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (key_s_q == 10'd0) begin
                    state_d = IDLE;
                end else begin
                    sample_d = key_s_q;
                    cnt_d    = '0;
                end
            end
            EMIT: begin
                emit    = 1'b1;
                state_d = HOLD;
                cnt_d   = '0;
`ifdef KEY_REPEAT_EN
                rpt_arm_d   = 1'b1;
                rpt_first_d = 1'b1;
                rpt_cnt_d   = '0;
`endif
            end
            HOLD: begin
                // cnt_q now counts consecutive released samples.
                if (key_s_q != 10'd0) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`ifdef KEY_REPEAT_EN
                if (key_s_q != sample_q) begin
                    rpt_arm_d = 1'b0;
                end else if (rpt_arm_q) begin
                    if (rpt_cnt_q == (rpt_first_q ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
                        emit        = 1'b1;
                        rpt_cnt_d   = '0;
                        rpt_first_d = 1'b0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (clr_overrun) overrun_d = 1'b0;

        // A dropped emission sets overrun after the clear so that set wins.
        if (emit) begin
            if (out_free) begin
                bcd_d       = key_code(sample_q);
                bcd_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (bcd_valid_q && bcd_ready) begin
            bcd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            key_s_q     <= '0;
            state_q     <= IDLE;
            sample_q    <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
            multi_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_arm_q   <= 1'b0;
            rpt_first_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            key_s_q     <= key_s_d;
            state_q     <= state_d;
            sample_q    <= sample_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
            multi_err_q <= multi_err_d;
            overrun_q   <= overrun_d;
`ifdef KEY_REPEAT_EN
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_arm_q   <= rpt_arm_d;
            rpt_first_q <= rpt_first_d;
`endif
        end
    end

    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign multi_err = multi_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Scoreboard bench for keypad_bcd_encoder: directed scenarios plus randomized bouncy presses.
module tb_keypad_bcd_encoder;
    localparam int D  = 4;
    localparam int RD = 64;
    localparam int RP = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] key_in;
    logic [3:0] bcd;
    logic       bcd_valid;
    logic       bcd_ready;
    logic       multi_err;
    logic       overrun;
    logic       clr_overrun;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int multi_seen = 0;
    int hs_seen = 0;
    int multi_exp = 0;
    bit rand_ready = 1'b0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;

    always #5 clk = ~clk;

    keypad_bcd_encoder #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .key_in(key_in),
        .bcd(bcd),
        .bcd_valid(bcd_valid),
        .bcd_ready(bcd_ready),
        .multi_err(multi_err),
        .overrun(overrun),
        .clr_overrun(clr_overrun),
        .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, a handshake happens at the next rising edge.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (multi_err === 1'b1) multi_seen++;
            if (bcd_valid === 1'b1 && bcd_ready === 1'b1) begin
                hs_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_handshake: got bcd=%0d expected no output", bcd);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("handshake_bcd", bcd, mon_exp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) bcd_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bcd_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bcd"}, bcd, 0);
        check({tag, "_bcd_valid"}, bcd_valid, 0);
        check({tag, "_multi_err"}, multi_err, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Reference model: a pattern held stable long enough yields its digit if exactly one key is down.
    task automatic model_press(input logic [9:0] p);
        if ($countones(p) == 1) begin
            for (int i = 0; i < 10; i++) if (p[i]) exp_q.push_back(4'(i));
        end else if ($countones(p) >= 2) begin
            multi_exp++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, hs0, m0;
        logic [9:0] p, prev;
        reset_n = 1'b0;
        key_in = '0;
        bcd_ready = 1'b1;
        clr_overrun = 1'b0;
        tick(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        tick(2);

        // Single clean press with latency measurement.
        hs0 = hs_seen;
        key_in = 10'h008;
        exp_q.push_back(4'd3);
        wait_valid(lat);
        check("latency_key3", lat, D + 4);
        tick(40 - lat);
        key_in = '0;
        tick(10);
        check("busy_after_release", busy, 0);
        check("handshakes_key3", hs_seen - hs0, 1);

        // Bouncing key 7 settles into one press.
        hs0 = hs_seen;
        m0 = multi_seen;
        for (int i = 0; i < 6; i++) begin
            key_in = (i % 2 == 0) ? 10'h080 : 10'h000;
            tick(2);
        end
        key_in = 10'h080;
        exp_q.push_back(4'd7);
        tick(20);
        key_in = '0;
        tick(12);
        check("handshakes_key7", hs_seen - hs0, 1);
        check("multi_none_key7", multi_seen - m0, 0);

        // Two keys together: error pulse, no code.
        hs0 = hs_seen;
        m0 = multi_seen;
        key_in = 10'h024;
        tick(20);
        check("multi_valid_low", bcd_valid, 0);
        key_in = '0;
        tick(12);
        check("multi_pulses", multi_seen - m0, 1);
        check("multi_no_handshake", hs_seen - hs0, 0);

        // Output register full: second press is dropped.
        bcd_ready = 1'b0;
        key_in = 10'h002;
        tick(D + 8);
        key_in = '0;
        tick(D + 8);
        key_in = 10'h200;
        tick(D + 8);
        check("ovr_valid", bcd_valid, 1);
        check("ovr_bcd", bcd, 1);
        check("ovr_flag", overrun, 1);
        exp_q.push_back(4'd1);
        bcd_ready = 1'b1;
        tick(1);
        bcd_ready = 1'b0;
        check("ovr_valid_dropped", bcd_valid, 0);
        check("ovr_bcd_kept", bcd, 1);
        check("ovr_flag_still", overrun, 1);
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        check("ovr_cleared", overrun, 0);
        key_in = '0;
        tick(D + 8);
        bcd_ready = 1'b1;
        tick(2);

        // Reset while key 4 is being debounced; key held through release.
        hs0 = hs_seen;
        key_in = 10'h010;
        tick(4);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        tick(2);
        check("midreset_busy_hold", busy, 0);
        reset_n = 1'b1;
        exp_q.push_back(4'd4);
        wait_valid(lat);
        check("latency_after_reset", lat, D + 4);
        tick(15);
        key_in = '0;
        tick(12);
        check("handshakes_key4", hs_seen - hs0, 1);

`ifdef KEY_REPEAT_EN
        // Held key 0 auto-repeats: first code plus six repeats in 150 cycles.
        hs0 = hs_seen;
        key_in = 10'h001;
        for (int i = 0; i < 7; i++) exp_q.push_back(4'd0);
        wait_valid(lat);
        check("repeat_first_latency", lat, D + 4);
        tick(150);
        key_in = '0;
        tick(15);
        check("repeat_handshakes", hs_seen - hs0, 7);
`endif

        // Randomized bouncy presses with random consumer back-pressure.
        m0 = multi_seen;
        multi_exp = 0;
        rand_ready = 1'b1;
        for (int it = 0; it < 25; it++) begin
            prev = '0;
            for (int b = 0; b < int'($urandom_range(0, 4)); b++) begin
                do p = 10'($urandom_range(0, 1023)); while (p == prev);
                key_in = p;
                prev = p;
                tick($urandom_range(1, D - 1));
            end
            if ($urandom_range(0, 1) == 0) begin
                p = 10'd1 << $urandom_range(0, 9);
            end else begin
                do p = 10'($urandom_range(0, 1023)); while ($countones(p) < 2);
            end
            key_in = p;
            model_press(p);
            tick(D + 8 + $urandom_range(0, 20));
            key_in = '0;
            tick(D + 6);
        end
        rand_ready = 1'b0;
        bcd_ready = 1'b1;
        tick(5);
        check("rand_multi_pulses", multi_seen - m0, multi_exp);
        check("rand_queue_drained", exp_q.size(), 0);
        check("rand_no_overrun", overrun, 0);
        check("rand_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_bcd_encoder.md
Name: keypad_bcd_encoder

Overview:
- Converts a 10-key decimal keypad (one line per digit 0-9) into a 4-bit BCD code.
- It is the encoding counterpart to the team's one-hot BCD-to-decimal decoder.
- Synchronises and debounces raw key lines, rejects multi-key presses, and emits one BCD code per key press on a valid/ready output register.
- Sits between the board keypad pins and the digit-consuming logic (display/accumulator).

Parameters:
- DEBOUNCE_CYCLES, 16, cycles the synchronised key pattern must stay unchanged before it is accepted; legal range 2..65535.
- REPEAT_DELAY, 64, cycles from first emission to first auto-repeat (used only with KEY_REPEAT_EN).
- REPEAT_PERIOD, 16, cycles between auto-repeats (used only with KEY_REPEAT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- key_in  in  10  raw key lines, bit i = digit i pressed (asynchronous, bouncy).
- bcd  out  4  encoded digit 0..9.
- bcd_valid  out  1  bcd holds an unconsumed code.
- bcd_ready  in  1  consumer accepts bcd when bcd_valid & bcd_ready.
- multi_err  out  1  one-cycle pulse: debounced pattern had more than one key.
- overrun  out  1  sticky: a press was dropped because the output register was full.
- clr_overrun  in  1  synchronous clear of overrun.
- busy  out  1  high whenever FSM is not in IDLE.

Behaviour:
- Interface: one clock, clk; reset_n is asynchronous, active-low. All flops reset to 0: sync stages, state=IDLE, counters, bcd=0, bcd_valid=0, multi_err=0, overrun=0.
- key_in passes through a 2-FF synchroniser giving key_s. Classification of key_s: NONE (0 bits set), SINGLE (1 bit; code = bit index), MULTI (2+ bits).
- FSM states and transitions:
  - IDLE: key_s != 0 -> DEBOUNCE; latch sample = key_s, cnt = 0.
  - DEBOUNCE, key_s == sample: cnt++. When cnt == DEBOUNCE_CYCLES-1, SINGLE -> EMIT; MULTI -> pulse multi_err, go to HOLD.
  - DEBOUNCE, key_s != sample: key_s == 0 -> IDLE; else re-latch sample and set cnt = 0.
  - EMIT (one cycle): load the output register if free, else set overrun. Then -> HOLD.
  - HOLD: wait for key_s == 0 unchanged for DEBOUNCE_CYCLES cycles, then -> IDLE. Any nonzero key_s clears the release counter. Pattern changes while held (e.g. second key added) emit nothing.
- Output register:
  - Free when bcd_valid == 0, or when bcd_valid & bcd_ready in the same cycle.
  - Load sets bcd = code and bcd_valid = 1.
  - Handshake without load clears bcd_valid; bcd keeps its last value.
  - Handshake and load in the same cycle: new code is loaded and bcd_valid stays 1.
  - No combinational path from bcd_ready to bcd_valid.
- overrun: set on a dropped EMIT. clr_overrun clears it. Set and clear in the same cycle: set wins.
- Latency: key_in stable from edge N -> bcd_valid high after edge N+DEBOUNCE_CYCLES+3; exact, to be checked by the bench.
- Reset mid-operation: any pending code is lost. A key still held at reset release is treated as a new press.
- Codes 10-15 are never produced.

Optional Feature:
- KEY_REPEAT_EN defined: a SINGLE key held in HOLD re-emits the same code REPEAT_DELAY cycles after the EMIT cycle, then every REPEAT_PERIOD cycles.
  - Each repeat follows the normal load/overrun rules.
  - Repeat timing is cancelled by any key_s change.
- KEY_REPEAT_EN not defined: one emission per press; REPEAT_* parameters are unused and no repeat counter is synthesised.

Test Plan:
- DEBOUNCE_CYCLES=4, bcd_ready=1, key_in=10'h008 held 40 cycles -> exactly one handshake with bcd=3, bcd_valid rising 7 cycles after key_in stable; then release, 10 idle cycles, busy returns to 0.
- key_in toggles 10'h080/10'h000 every 2 cycles for 12 cycles, then holds 10'h080 -> exactly one bcd=7 handshake, no multi_err.
- key_in=10'h024 (keys 2 and 5) held 20 cycles -> one multi_err pulse, bcd_valid stays 0.
- bcd_ready=0: press and release key 1, then press key 9 -> bcd=1 held, overrun=1. Then bcd_ready=1 for one cycle -> bcd_valid drops; clr_overrun -> overrun=0.
- reset_n pulsed low mid-DEBOUNCE with key 4 held -> all outputs 0 during reset. After release, bcd=4 emitted once, DEBOUNCE_CYCLES+3 cycles later.
- KEY_REPEAT_EN, REPEAT_DELAY=64, REPEAT_PERIOD=16, bcd_ready=1: key 0 held for 150 cycles after first bcd_valid -> 7 handshakes, all bcd=0.
